// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clkdiv_multi channel dividers.
// Functions work on 32-bit values; callers cast to their own counter width (CW <= 32).
package clkdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam int MIN_DIV = 2;

   function automatic logic [31:0] clamp_div(input logic [31:0] n);
      return (n < 32'(MIN_DIV)) ? 32'(MIN_DIV) : n;
   endfunction

   function automatic logic [31:0] half_up(input logic [31:0] n);
      return (n >> 1) + {31'd0, n[0]};
   endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: programmable ratio applied at period wrap, ~50% duty clock plus ce pulse.
// Latency 1 clk from run/step to first edge; no backpressure. CLKDIV_STEP_EN adds single-period step.
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int CW      = 16,
   parameter int DEF_DIV = 18
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [CW-1:0] i_div_cfg,
   input  logic          i_cfg_load,
   input  logic          i_run,
`ifdef CLKDIV_STEP_EN
   input  logic          i_step,
`endif
   output logic          o_clk_out,
   output logic          o_ce_out,
   output logic          o_cfg_busy
);

   localparam logic [CW-1:0] RST_DIV = CW'(clamp_div(32'(DEF_DIV)));
   localparam logic [CW-1:0] RST_HI  = CW'(half_up(clamp_div(32'(DEF_DIV))));

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, r_act_div, r_hi_len, r_pend_div;
   logic [CW-1:0] w_cnt_inc, w_cnt_nxt, w_cfg_div, w_pend_hi;
   logic          r_pend_vld, r_clk_out, r_ce_out;
   logic          w_wrap, w_apply, w_clk_nxt, w_ce_nxt, w_step;

`ifdef CLKDIV_STEP_EN
   assign w_step = i_step;
`else
   assign w_step = 1'b0;
`endif

   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_wrap    = (r_cnt == r_act_div - CW'(1));
   assign w_cfg_div = CW'(clamp_div(32'(i_div_cfg)));
   assign w_pend_hi = CW'(half_up(32'(r_pend_div)));
   // Idle channels take a pending ratio at once; running ones only at the wrap edge.
   assign w_apply   = r_pend_vld && ((r_state == ST_IDLE) || w_wrap);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_run)       w_state_nxt = ST_RUN;
            else if (w_step) w_state_nxt = ST_STEP;
         end
         ST_RUN: begin
            if (!i_run) w_state_nxt = ST_IDLE;
         end
         ST_STEP: begin
            if (i_run)       w_state_nxt = ST_RUN;
            else if (w_wrap) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Every edge into an active state from IDLE, and every wrap that stays active, starts a period.
   always_comb begin
      w_cnt_nxt = '0;
      w_clk_nxt = 1'b0;
      w_ce_nxt  = 1'b0;
      if (w_state_nxt != ST_IDLE) begin
         if ((r_state == ST_IDLE) || w_wrap) begin
            w_clk_nxt = 1'b1;
            w_ce_nxt  = 1'b1;
         end else begin
            w_cnt_nxt = w_cnt_inc;
            w_clk_nxt = (w_cnt_inc < r_hi_len);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_act_div  <= RST_DIV;
         r_hi_len   <= RST_HI;
         r_pend_div <= '0;
         r_pend_vld <= 1'b0;
         r_clk_out  <= 1'b0;
         r_ce_out   <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_clk_out <= w_clk_nxt;
         r_ce_out  <= w_ce_nxt;
         if (w_apply) begin
            r_act_div <= r_pend_div;
            r_hi_len  <= w_pend_hi;
         end
         // A load on an applying edge becomes the next pending value.
         if (i_cfg_load) begin
            r_pend_div <= w_cfg_div;
            r_pend_vld <= 1'b1;
         end else if (w_apply) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

   assign o_clk_out  = r_clk_out;
   assign o_ce_out   = r_ce_out;
   assign o_cfg_busy = r_pend_vld;

endmodule

// File: rtl/clkdiv_multi.sv
// CH independent clock dividers with runtime ratio, ce pulse and run gate; outputs registered, 1 clk latency.
// No backpressure. Optional single-period step input under CLKDIV_STEP_EN.
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter int CH      = 2,
   parameter int CW      = 16,
   parameter int DEF_DIV = 18
) (
   input  logic [CH*CW-1:0] i_div_cfg,
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [CH-1:0]    i_cfg_load,
   input  logic [CH-1:0]    i_run,
`ifdef CLKDIV_STEP_EN
   input  logic [CH-1:0]    i_step,
`endif
   output logic [CH-1:0]    o_clk_out,
   output logic [CH-1:0]    o_ce_out,
   output logic [CH-1:0]    o_cfg_busy
);

   for (genvar k = 0; k < CH; k++) begin : g_chan
      clkdiv_chan #(
         .CW      (CW),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_div_cfg  (i_div_cfg[k*CW +: CW]),
         .i_cfg_load (i_cfg_load[k]),
         .i_run      (i_run[k]),
`ifdef CLKDIV_STEP_EN
         .i_step     (i_step[k]),
`endif
         .o_clk_out  (o_clk_out[k]),
         .o_ce_out   (o_ce_out[k]),
         .o_cfg_busy (o_cfg_busy[k])
      );
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi (CH=2, CW=16, DEF_DIV=18); step sequence only with CLKDIV_STEP_EN.
module tb_clkdiv_multi;

   logic        clk;
   logic        rst_n;
   logic [31:0] div_cfg;
   logic [1:0]  cfg_load;
   logic [1:0]  run;
`ifdef CLKDIV_STEP_EN
   logic [1:0]  step;
`endif
   logic [1:0]  clk_out;
   logic [1:0]  ce_out;
   logic [1:0]  cfg_busy;

   int n_tests = 0;
   int n_fail  = 0;
   int hi, lo, bad, cyc, cnt_hi, cnt_ce;

   typedef struct {
      int          ch;
      logic [15:0] n;
      int          hi;
      int          lo;
   } vec_t;
   vec_t vec[8];

   clkdiv_multi #(.CH(2), .CW(16), .DEF_DIV(18)) dut (
      .i_div_cfg  (div_cfg),
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_cfg_load (cfg_load),
      .i_run      (run),
`ifdef CLKDIV_STEP_EN
      .i_step     (step),
`endif
      .o_clk_out  (clk_out),
      .o_ce_out   (ce_out),
      .o_cfg_busy (cfg_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_ch(input int ch, input logic [15:0] n);
      div_cfg[ch*16 +: 16] = n;
      cfg_load[ch] = 1'b1;
      @(negedge clk);
      cfg_load = '0;
   endtask

   task automatic wait_busy(input int ch, output int c);
      c = 0;
      while (cfg_busy[ch] && c < 300) begin
         @(negedge clk);
         c++;
      end
      if (cfg_busy[ch]) c = -1;
   endtask

   task automatic wait_ce(input int ch);
      int n;
      n = 0;
      while (ce_out[ch] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Starts at (or waits for) a ce sample, counts one period, ends on the next ce sample.
   task automatic measure(input int ch, output int h, output int l, output int b);
      int  n;
      bit  seen_lo;
      h = 0; l = 0; b = 0; n = 0; seen_lo = 1'b0;
      while (ce_out[ch] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (ce_out[ch] !== 1'b1) begin
         h = -1; l = -1;
         return;
      end
      do begin
         if (clk_out[ch] === 1'b1) begin
            h++;
            if (seen_lo) b++;
         end else begin
            l++;
            seen_lo = 1'b1;
         end
         @(negedge clk);
         n++;
      end while (ce_out[ch] !== 1'b1 && n < 200);
      if (ce_out[ch] !== 1'b1) b++;
   endtask

   initial begin
      vec[0] = '{ch: 0, n: 16'd0,  hi: 1, lo: 1};
      vec[1] = '{ch: 0, n: 16'd1,  hi: 1, lo: 1};
      vec[2] = '{ch: 1, n: 16'd2,  hi: 1, lo: 1};
      vec[3] = '{ch: 1, n: 16'd3,  hi: 2, lo: 1};
      vec[4] = '{ch: 0, n: 16'd10, hi: 5, lo: 5};
      vec[5] = '{ch: 1, n: 16'd7,  hi: 4, lo: 3};
      vec[6] = '{ch: 0, n: 16'd4,  hi: 2, lo: 2};
      vec[7] = '{ch: 1, n: 16'd18, hi: 9, lo: 9};

      rst_n = 1'b0; run = 2'b11; div_cfg = '0; cfg_load = '0;
`ifdef CLKDIV_STEP_EN
      step = '0;
`endif
      repeat (2) @(negedge clk);
      check("rst_clk_out", int'(clk_out), 0);
      check("rst_ce_out", int'(ce_out), 0);
      check("rst_busy", int'(cfg_busy), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("first_ce", int'(ce_out), 3);
      check("first_clk", int'(clk_out), 3);
      measure(0, hi, lo, bad);
      check("def_hi", hi, 9);
      check("def_lo", lo, 9);
      check("def_shape", bad, 0);

      // ratio 5 loaded at cnt=4 of the default 18-cycle period
      repeat (4) @(negedge clk);
      load_ch(0, 16'd5);
      check("n5_busy", int'(cfg_busy[0]), 1);
      wait_busy(0, cyc);
      check("n5_busy_cycles", cyc, 13);
      check("n5_ce_at_apply", int'(ce_out[0]), 1);
      measure(0, hi, lo, bad);
      check("n5_hi", hi, 3);
      check("n5_lo", lo, 2);
      measure(1, hi, lo, bad);
      check("ch1_untouched_hi", hi, 9);
      check("ch1_untouched_lo", lo, 9);

      for (int i = 0; i < 8; i++) begin
         load_ch(vec[i].ch, vec[i].n);
         wait_busy(vec[i].ch, cyc);
         check($sformatf("v%0d_busy_drop", i), int'(cyc > 0), 1);
         check($sformatf("v%0d_ce_at_apply", i), int'(ce_out[vec[i].ch]), 1);
         measure(vec[i].ch, hi, lo, bad);
         check($sformatf("v%0d_hi", i), hi, vec[i].hi);
         check($sformatf("v%0d_lo", i), lo, vec[i].lo);
         check($sformatf("v%0d_shape", i), bad, 0);
      end

      // load on the wrap edge of ch0 (N=4): old period runs once more, then 3
      wait_ce(0);
      repeat (3) @(negedge clk);
      load_ch(0, 16'd3);
      check("wrapload_ce", int'(ce_out[0]), 1);
      check("wrapload_busy", int'(cfg_busy[0]), 1);
      measure(0, hi, lo, bad);
      check("wrapload_old_hi", hi, 2);
      check("wrapload_old_lo", lo, 2);
      check("wrapload_busy_clr", int'(cfg_busy[0]), 0);
      measure(0, hi, lo, bad);
      check("wrapload_new_hi", hi, 2);
      check("wrapload_new_lo", lo, 1);

      // two loads in one period on ch1 (N=18): 7 then 4, only 4 appears
      wait_ce(1);
      load_ch(1, 16'd7);
      load_ch(1, 16'd4);
      check("dbl_busy", int'(cfg_busy[1]), 1);
      wait_busy(1, cyc);
      check("dbl_busy_drop", int'(cyc > 0), 1);
      for (int p = 0; p < 2; p++) begin
         measure(1, hi, lo, bad);
         check($sformatf("dbl_p%0d_hi", p), hi, 2);
         check($sformatf("dbl_p%0d_lo", p), lo, 2);
      end

      // run dropped at cnt=3 of N=10
      load_ch(0, 16'd10);
      wait_busy(0, cyc);
      repeat (3) @(negedge clk);
      run[0] = 1'b0;
      @(negedge clk);
      check("stop_clk", int'(clk_out[0]), 0);
      check("stop_ce", int'(ce_out[0]), 0);
      cnt_hi = 0; cnt_ce = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cnt_hi += int'(clk_out[0]);
         cnt_ce += int'(ce_out[0]);
      end
      check("idle_clk_cnt", cnt_hi, 0);
      check("idle_ce_cnt", cnt_ce, 0);
      run[0] = 1'b1;
      @(negedge clk);
      check("restart_ce", int'(ce_out[0]), 1);
      load_ch(0, 16'd6);
      check("pre_rst_busy", int'(cfg_busy[0]), 1);
      check("pre_rst_clk", int'(clk_out[0]), 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_clk", int'(clk_out), 0);
      check("async_rst_ce", int'(ce_out), 0);
      check("async_rst_busy", int'(cfg_busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rerst_ce", int'(ce_out), 3);
      measure(0, hi, lo, bad);
      check("rerst_hi", hi, 9);
      check("rerst_lo", lo, 9);

`ifdef CLKDIV_STEP_EN
      run = 2'b00;
      repeat (2) @(negedge clk);
      load_ch(0, 16'd6);
      repeat (2) @(negedge clk);
      check("step_idle_busy", int'(cfg_busy[0]), 0);
      check("step_idle_clk", int'(clk_out[0]), 0);
      step[0] = 1'b1;
      @(negedge clk);
      step[0] = 1'b0;
      check("step_first_ce", int'(ce_out[0]), 1);
      cnt_hi = 0; cnt_ce = 0;
      for (int i = 0; i < 20; i++) begin
         cnt_hi += int'(clk_out[0]);
         cnt_ce += int'(ce_out[0]);
         if (i == 1) step[0] = 1'b1;
         if (i == 2) step[0] = 1'b0;
         @(negedge clk);
      end
      check("step_hi_cycles", cnt_hi, 3);
      check("step_ce_count", cnt_ce, 1);
      check("step_end_clk", int'(clk_out[0]), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised multi-channel clock divider for the monitor/CPU clocking tree. It replaces the fixed divide-by-18 CPU clock generator. Each channel has a runtime-programmable ratio with glitch-free changes at period boundaries, near-50% duty for odd and even ratios, a one-cycle clock-enable pulse per period and a per-channel run gate. All outputs are registered in the single `clk` domain.

## Interface
- `CH`, 2, number of independent divider channels (1..8)
- `CW`, 16, ratio/counter width in bits
- `DEF_DIV`, 18, ratio loaded into every channel at reset (must be ≥2)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous and active-low
- `div_cfg`  in  CH*CW  per-channel requested ratio N; channel k uses bits [k*CW +: CW]
- `cfg_load`  in  CH  one-cycle pulse; samples the channel's `div_cfg` into its pending register
- `run`  in  CH  level; channel free-runs while high
- `clk_out`  out  CH  divided clock (registered, for use as a data/enable signal or a BUFG input)
- `ce_out`  out  CH  one-cycle pulse coincident with each `clk_out` rising edge
- `cfg_busy`  out  CH  pending ratio not yet applied
- `step`  in  CH  single-period request (present only with `CLKDIV_STEP_EN`)

## Operation
- Per channel: `cnt` (CW bits), `act_div`, `hi_len` = ceil(act_div/2), `pend_div`, `pend_vld`, state.
- Ratio clamp: a sampled N<2 is stored as 2. Counting uses CW bits and never overflows, because cnt ≤ act_div−1.
- States are IDLE and RUN, plus STEP when the macro is defined.
- IDLE: cnt=0, `clk_out`=0, `ce_out`=0. A pending ratio is applied immediately, and `cfg_busy` drops the next cycle.
- IDLE→RUN when `run`=1. The transition edge is the period start: cnt←0, `clk_out`←1, `ce_out`←1.
- RUN, when cnt==act_div−1: wrap to cnt←0, `clk_out`←1, `ce_out`←1. If `pend_vld` is set, act_div and hi_len take the pending value on this same edge, and `pend_vld` clears.
- RUN, otherwise: cnt←cnt+1, `ce_out`←0, `clk_out`←(cnt+1 < hi_len).
- RUN→IDLE when `run`=0. The transition is immediate: the next edge forces outputs low and cnt to 0, and a truncated period is allowed.
- `cfg_load` while `pend_vld` is set overwrites the pending value; last write wins.
- `cfg_load` on the same edge as a wrap: the wrap applies the old pending value (if any), and the new value becomes pending.
- `cfg_busy` = `pend_vld`.
- Channels are fully independent. There is no phase alignment between channels.

## Timing
- Reset values: `clk_out`=0, `ce_out`=0, `cfg_busy`=0, act_div=DEF_DIV, state IDLE.
- Latency: from `run` sampled high to `ce_out`/`clk_out` high is 1 clk edge.
- Period is exactly act_div cycles. `clk_out` is high for ceil(N/2) cycles and low for floor(N/2). N=2 gives alternating cycles; N=3 gives 2 high, 1 low.
- A new ratio takes effect on the first wrap edge after the load. The old period always completes.
- Reset mid-period returns the channel to IDLE asynchronously and discards any pending ratio.

## Configuration
- `CLKDIV_STEP_EN` defined: adds the `step` port and the STEP state.
  - In IDLE, a `step` pulse enters STEP with a period-start edge.
  - STEP produces exactly one full period, then returns to IDLE at cnt==act_div−1 instead of wrapping.
  - `run`=1 in STEP moves to RUN without truncating the current period.
  - `step` is ignored in RUN and STEP.
- Not defined: no `step` port; `run` is the only start source.

## Structure
- `clkdiv_pkg`: state enum (IDLE/RUN/STEP), `MIN_DIV`=2, clamp function `clamp_div`, function for ceil(N/2).
- One sub-module, `clkdiv_chan`, implements a single channel. `clkdiv_multi` instantiates it CH times in a generate loop and slices the vectors.

## Test plan
- Reset with `run`=1, DEF_DIV=18 → first `ce_out` 1 edge after `rst_n` rise; `clk_out` high 9 cycles, low 9 cycles; `ce_out` every 18 cycles.
- Load N=5 on ch0 mid-period → old 18-cycle period completes, `cfg_busy` high until that wrap; then `clk_out` pattern is 3 high / 2 low, period 5. ch1 is unaffected.
- Load N=0, then separately N=1 → both behave as N=2 (toggle every cycle, `ce_out` every 2 cycles).
- Two `cfg_load`s (7 then 4) within one period → period after the wrap is 4; 7 is never seen.
- `run` dropped at cnt=3 of N=10, then `rst_n` pulsed low while running → outputs 0 the next edge; on reset, outputs 0 asynchronously, `cfg_busy`=0, act_div back to 18.
- With `CLKDIV_STEP_EN`, N=6, `run`=0, single `step` pulse → exactly one `ce_out` and one 3-high/3-low period, then IDLE. A second `step` during STEP produces nothing extra.
